// File: rtl/csr_pkg.sv
// Shared CSR addresses, op encoding and trap FSM states for the machine-mode CSR/trap block.
package csr_pkg;

  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_W    = 2'b01,
    CSR_S    = 2'b10,
    CSR_C    = 2'b11
  } csr_op_t;

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } trap_state_t;

endpackage

// File: rtl/csr_alu_riscv.sv
// Combinational CSR read-modify-write: next value from old value, operand and op.
module csr_alu_riscv
  import csr_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_old,
  input  logic [W-1:0] i_wdata,
  input  logic [1:0]   i_op,
  output logic [W-1:0] o_new
);

  always_comb begin
    o_new = i_old;
    case (csr_op_t'(i_op))
      CSR_W:   o_new = i_wdata;
      CSR_S:   o_new = i_old | i_wdata;
      CSR_C:   o_new = i_old & ~i_wdata;
      default: o_new = i_old;
    endcase
  end

endmodule

// File: rtl/csr_trap_riscv.sv
// Machine-mode CSR bank plus IDLE/HANDLER trap sequencer answering the interrupt controller.
module csr_trap_riscv
  import csr_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            irq_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic [XLEN-1:0] mie_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] trap_pc_o,
  output logic            trap_take_o,
  output logic            irq_fin_o,
  output logic            in_handler_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause;
  trap_state_t     r_state;
  logic            r_irq_fin;

  logic [XLEN-1:0] w_new;
  logic            w_active, w_take;
  logic            w_wr_mie, w_wr_mtvec, w_wr_mscratch, w_wr_mepc, w_wr_mcause;

  // Old value of the addressed CSR; also the ALU's read operand.
  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MIE:      csr_rdata_o = r_mie;
      CSR_MTVEC:    csr_rdata_o = r_mtvec;
      CSR_MSCRATCH: csr_rdata_o = r_mscratch;
      CSR_MEPC:     csr_rdata_o = r_mepc;
      CSR_MCAUSE:   csr_rdata_o = r_mcause;
      default:      csr_rdata_o = '0;
    endcase
  end

  csr_alu_riscv #(.W(XLEN)) u_alu (
    .i_old   (csr_rdata_o),
    .i_wdata (csr_wdata_i),
    .i_op    (csr_op_i),
    .o_new   (w_new)
  );

  assign w_active      = (csr_op_t'(csr_op_i) != CSR_NONE);
  assign w_wr_mie      = w_active && (csr_addr_i == CSR_MIE);
  assign w_wr_mtvec    = w_active && (csr_addr_i == CSR_MTVEC);
  assign w_wr_mscratch = w_active && (csr_addr_i == CSR_MSCRATCH);
  assign w_wr_mepc     = w_active && (csr_addr_i == CSR_MEPC);
  assign w_wr_mcause   = w_active && (csr_addr_i == CSR_MCAUSE);

  // No nesting: an interrupt is only accepted from IDLE, and it beats a concurrent mret.
  assign w_take      = irq_i && (r_state == IDLE);
  assign trap_take_o = w_take;
  assign trap_pc_o   = (mret_i && !w_take) ? r_mepc : r_mtvec;

  assign mie_o        = r_mie;
  assign mtvec_o      = r_mtvec;
  assign mepc_o       = r_mepc;
  assign irq_fin_o    = r_irq_fin;
  assign in_handler_o = (r_state == HANDLER);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mie      <= '0;
      r_mtvec    <= XLEN'(MTVEC_RST) & ALIGN_MASK;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_state    <= IDLE;
      r_irq_fin  <= 1'b0;
    end else begin
      if (w_wr_mie)      r_mie      <= w_new;
      if (w_wr_mtvec)    r_mtvec    <= w_new & ALIGN_MASK;
      if (w_wr_mscratch) r_mscratch <= w_new;

      // Trap capture takes priority over software writes to mepc/mcause.
      if (w_take)         r_mepc <= pc_i & ALIGN_MASK;
      else if (w_wr_mepc) r_mepc <= w_new & ALIGN_MASK;

      if (w_take)           r_mcause <= mcause_i;
      else if (w_wr_mcause) r_mcause <= w_new;

      r_irq_fin <= 1'b0;
      case (r_state)
        IDLE: begin
          if (irq_i) r_state <= HANDLER;
        end
        HANDLER: begin
          if (mret_i) begin
            r_state   <= IDLE;
            r_irq_fin <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_riscv.sv
// Vector-table bench for csr_trap_riscv with a queue of expected post-edge state.
module tb_csr_trap_riscv;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0200;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i, pc_i, mcause_i;
  logic        irq_i, mret_i;
  logic [31:0] csr_rdata_o, mie_o, mtvec_o, mepc_o, trap_pc_o;
  logic        trap_take_o, irq_fin_o, in_handler_o;

  int total = 0;
  int bad   = 0;

  csr_trap_riscv #(.XLEN(32), .MTVEC_RST(MTVEC_RST)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .csr_op_i     (csr_op_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .pc_i         (pc_i),
    .irq_i        (irq_i),
    .mcause_i     (mcause_i),
    .mret_i       (mret_i),
    .csr_rdata_o  (csr_rdata_o),
    .mie_o        (mie_o),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .trap_pc_o    (trap_pc_o),
    .trap_take_o  (trap_take_o),
    .irq_fin_o    (irq_fin_o),
    .in_handler_o (in_handler_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        irq;
    logic [31:0] mc;
    logic        mret;
    logic [31:0] e_rdata;
    logic        e_take;
    logic [31:0] e_tpc;
    logic [31:0] e_mie;
    logic [31:0] e_mtvec;
    logic [31:0] e_mepc;
    logic        e_inh;
    logic        e_fin;
  } vec_t;

  typedef struct {
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        inh;
    logic        fin;
  } post_t;

  vec_t  vecs[$];
  post_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [31:0] pc, input logic irq, input logic [31:0] mc, input logic mret,
                     input logic [31:0] e_rdata, input logic e_take, input logic [31:0] e_tpc,
                     input logic [31:0] e_mie, input logic [31:0] e_mtvec, input logic [31:0] e_mepc,
                     input logic e_inh, input logic e_fin);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.pc = pc; v.irq = irq; v.mc = mc; v.mret = mret;
    v.e_rdata = e_rdata; v.e_take = e_take; v.e_tpc = e_tpc; v.e_mie = e_mie;
    v.e_mtvec = e_mtvec; v.e_mepc = e_mepc; v.e_inh = e_inh; v.e_fin = e_fin;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic irq, input logic [31:0] mc, input logic mret);
    csr_op_i = op; csr_addr_i = addr; csr_wdata_i = wdata;
    pc_i = pc; irq_i = irq; mcause_i = mc; mret_i = mret;
  endtask

  task automatic check_post(input string tag);
    post_t p;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty got=0 want=1", tag);
    end else begin
      p = sb.pop_front();
      chk({tag, ".mie"},   mie_o,   p.mie);
      chk({tag, ".mtvec"}, mtvec_o, p.mtvec);
      chk({tag, ".mepc"},  mepc_o,  p.mepc);
      chk({tag, ".inh"},   32'(in_handler_o), 32'(p.inh));
      chk({tag, ".fin"},   32'(irq_fin_o),    32'(p.fin));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    post_t p;
    // op, addr, wdata, pc, irq, mcause, mret | rdata, take, trap_pc | post: mie, mtvec, mepc, inh, fin
    add(2, 12'h304, 0, 0, 0, 0, 0,   32'h0,        0, 32'h200,  0, 32'h200, 32'h0,    0, 0);
    add(2, 12'h305, 0, 0, 0, 0, 0,   32'h200,      0, 32'h200,  0, 32'h200, 32'h0,    0, 0);
    add(2, 12'h340, 0, 0, 0, 0, 0,   32'h0,        0, 32'h200,  0, 32'h200, 32'h0,    0, 0);
    add(2, 12'h341, 0, 0, 0, 0, 0,   32'h0,        0, 32'h200,  0, 32'h200, 32'h0,    0, 0);
    add(2, 12'h342, 0, 0, 0, 0, 0,   32'h0,        0, 32'h200,  0, 32'h200, 32'h0,    0, 0);
    add(1, 12'h305, 32'h103, 0, 0, 0, 0, 32'h200,  0, 32'h200,  0, 32'h100, 32'h0,    0, 0);
    add(2, 12'h304, 32'h6, 0, 0, 0, 0,   32'h0,    0, 32'h100,  6, 32'h100, 32'h0,    0, 0);
    add(3, 12'h304, 32'h2, 0, 0, 0, 0,   32'h6,    0, 32'h100,  4, 32'h100, 32'h0,    0, 0);
    add(1, 12'h7C0, 32'hFFFF, 0, 0, 0, 0, 32'h0,   0, 32'h100,  4, 32'h100, 32'h0,    0, 0);
    add(2, 12'h7C0, 0, 0, 0, 0, 0,   32'h0,        0, 32'h100,  4, 32'h100, 32'h0,    0, 0);
    add(2, 12'h305, 0, 0, 0, 0, 0,   32'h100,      0, 32'h100,  4, 32'h100, 32'h0,    0, 0);
    add(1, 12'h340, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 0, 32'h100, 4, 32'h100, 32'h0,   0, 0);
    add(2, 12'h340, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF, 0, 32'h100, 4, 32'h100, 32'h0,  0, 0);
    add(2, 12'h340, 0, 0, 0, 0, 0,   32'hDEADBEFF, 0, 32'h100,  4, 32'h100, 32'h0,    0, 0);
    add(0, 12'h000, 0, 32'hA46, 1, 5, 0, 32'h0,    1, 32'h100,  4, 32'h100, 32'hA44,  1, 0);
    add(2, 12'h342, 0, 0, 0, 0, 0,   32'h5,        0, 32'h100,  4, 32'h100, 32'hA44,  1, 0);
    add(2, 12'h342, 0, 32'h500, 1, 7, 0, 32'h5,    0, 32'h100,  4, 32'h100, 32'hA44,  1, 0);
    add(2, 12'h342, 0, 0, 0, 0, 0,   32'h5,        0, 32'h100,  4, 32'h100, 32'hA44,  1, 0);
    add(0, 12'h000, 0, 0, 0, 0, 1,   32'h0,        0, 32'hA44,  4, 32'h100, 32'hA44,  0, 1);
    add(0, 12'h000, 0, 0, 0, 0, 0,   32'h0,        0, 32'h100,  4, 32'h100, 32'hA44,  0, 0);
    add(1, 12'h341, 32'h1234, 32'h2000, 1, 32'hB, 0, 32'hA44, 1, 32'h100, 4, 32'h100, 32'h2000, 1, 0);
    add(2, 12'h342, 0, 0, 0, 0, 0,   32'hB,        0, 32'h100,  4, 32'h100, 32'h2000, 1, 0);
    add(0, 12'h000, 0, 32'h3000, 1, 3, 1, 32'h0,   0, 32'h2000, 4, 32'h100, 32'h2000, 0, 1);
    add(2, 12'h342, 0, 0, 0, 0, 0,   32'hB,        0, 32'h100,  4, 32'h100, 32'h2000, 0, 0);
    add(1, 12'h340, 32'h55, 32'h4008, 1, 9, 1, 32'hDEADBEFF, 1, 32'h100, 4, 32'h100, 32'h4008, 1, 0);
    add(2, 12'h340, 0, 0, 0, 0, 1,   32'h55,       0, 32'h4008, 4, 32'h100, 32'h4008, 0, 1);
    add(0, 12'h000, 0, 0, 0, 0, 1,   32'h0,        0, 32'h4008, 4, 32'h100, 32'h4008, 0, 0);
    add(1, 12'h341, 32'h1237, 0, 0, 0, 0, 32'h4008, 0, 32'h100, 4, 32'h100, 32'h1234, 0, 0);
    add(3, 12'h341, 32'h4, 0, 0, 0, 0, 32'h1234,   0, 32'h100,  4, 32'h100, 32'h1230, 0, 0);
    add(1, 12'h342, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h9, 0, 32'h100, 4, 32'h100, 32'h1230, 0, 0);
    add(2, 12'h342, 0, 0, 0, 0, 0,   32'hFFFFFFFF, 0, 32'h100,  4, 32'h100, 32'h1230, 0, 0);

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    p.mie = 0; p.mtvec = MTVEC_RST; p.mepc = 0; p.inh = 0; p.fin = 0;
    sb.push_back(p);
    check_post("reset");

    // Table: drive right after an edge, check combinational outputs mid-cycle, check state after edge
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].pc, vecs[i].irq, vecs[i].mc, vecs[i].mret);
      p.mie = vecs[i].e_mie; p.mtvec = vecs[i].e_mtvec; p.mepc = vecs[i].e_mepc;
      p.inh = vecs[i].e_inh; p.fin = vecs[i].e_fin;
      sb.push_back(p);
      #4;
      if (vecs[i].op != 2'b00) chk({tag, ".rdata"}, csr_rdata_o, vecs[i].e_rdata);
      chk({tag, ".take"}, 32'(trap_take_o), 32'(vecs[i].e_take));
      chk({tag, ".tpc"},  trap_pc_o, vecs[i].e_tpc);
      @(posedge clk_i);
      #1;
      check_post(tag);
    end

    // Reset while in HANDLER, even with mret pending: no fin pulse, state and mepc cleared
    drive(0, 0, 0, 32'h8888, 1, 32'hC, 0);
    @(posedge clk_i); #1;
    chk("rst_seq.enter", 32'(in_handler_o), 32'h1);
    chk("rst_seq.mepc",  mepc_o, 32'h8888);
    drive(0, 0, 0, 0, 0, 0, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    p.mie = 0; p.mtvec = MTVEC_RST; p.mepc = 0; p.inh = 0; p.fin = 0;
    sb.push_back(p);
    check_post("rst_seq.reset");
    // mret in IDLE after reset must not pulse
    drive(0, 0, 0, 0, 0, 0, 1);
    #4;
    chk("rst_seq.tpc", trap_pc_o, 32'h0);
    @(posedge clk_i); #1;
    sb.push_back(p);
    check_post("rst_seq.idle_mret");
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    chk("rst_seq.fin_quiet", 32'(irq_fin_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
